// File: rtl/reset_pkg.sv
// rtl/reset_pkg.sv - shared types and constants for the reset sequencer
// Ports: none (package).
package reset_pkg;

  typedef enum logic [1:0] {
    HOLD,
    SYS_UP,
    HART_RST,
    RUN
  } rst_state_e;

  // A single flop cannot resolve metastability on the release edge.
  localparam int MinSyncStages = 2;

endpackage

// File: rtl/rst_sync.sv
// rtl/rst_sync.sv - async-assert, sync-release reset synchronizer
// Ports:
//   clk     in   clock of the destination domain
//   rst_n   in   raw reset, asynchronous active-low
//   rst_n_o out  reset that asserts with rst_n and releases on the Stages-th edge
module rst_sync
  import reset_pkg::*;
#(
  parameter int Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_o
);

  // Depth is clamped so a mis-set parameter still yields a real synchronizer.
  localparam int Depth = (Stages < MinSyncStages) ? MinSyncStages : Stages;

  logic [Depth-1:0] sync_q;
  logic [Depth-1:0] sync_d;

  // A one is shifted in from the bottom; the top bit is the released reset.
  always_comb begin
    sync_d = {sync_q[Depth-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_n_o = sync_q[Depth-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered dm/sys/hart reset release with debug reset requests
// Ports:
//   clk            in   system clock
//   rst_n          in   power-on reset, async assert, released through a synchronizer
//   ndmreset_req   in   level: hold sys and hart in reset while high
//   hartreset_req  in   level: hold hart in reset while high
//   ackhavereset   in   pulse: clear havereset
//   dm_rst_n       out  synchronized copy of rst_n
//   sys_rst_n      out  system/fabric reset, active-low
//   hart_rst_n     out  hart reset, active-low
//   havereset      out  sticky: hart has been reset since last ack
//   busy           out  high while the sequence is not in RUN
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int SyncStages = 2,
  parameter int SysDelay   = 4,
  parameter int HartDelay  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ndmreset_req,
  input  logic hartreset_req,
  input  logic ackhavereset,
  output logic dm_rst_n,
  output logic sys_rst_n,
  output logic hart_rst_n,
  output logic havereset,
  output logic busy
);

  localparam int MaxDelay = (SysDelay > HartDelay) ? SysDelay : HartDelay;
  localparam int CntW     = $clog2(MaxDelay + 1);

  localparam logic [CntW-1:0] SysLast  = CntW'(SysDelay - 1);
  localparam logic [CntW-1:0] HartLast = CntW'(HartDelay - 1);

  rst_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sys_rst_n_q, sys_rst_n_d;
  logic            hart_rst_n_q, hart_rst_n_d;
  logic            havereset_q, havereset_d;
  logic            busy_q, busy_d;
  logic            dm_rst_n_sync;

  rst_sync #(
    .Stages (SyncStages)
  ) u_dm_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_n_o (dm_rst_n_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      HOLD: begin
        if (ndmreset_req) begin
          cnt_d = '0;
        end else if (cnt_q == SysLast) begin
          state_d = SYS_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      SYS_UP: begin
        if (cnt_q == HartLast) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      HART_RST: begin
        if (hartreset_req) begin
          cnt_d = '0;
        end else if (cnt_q == HartLast) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase

    // Request overrides: ndmreset beats hartreset; hartreset is meaningless in
    // HOLD because the hart is already held there.
    if (ndmreset_req) begin
      state_d = HOLD;
      cnt_d   = '0;
    end else if (hartreset_req && (state_q == RUN || state_q == SYS_UP)) begin
      state_d = HART_RST;
      cnt_d   = '0;
    end

    // Outputs are registered from the next state so they move on the same
    // edge as the state and never glitch.
    sys_rst_n_d  = (state_d != HOLD);
    hart_rst_n_d = (state_d == RUN);
    busy_d       = (state_d != RUN);

    // The hart being captured in reset on this edge outranks an ack.
    if (!hart_rst_n_d) begin
      havereset_d = 1'b1;
    end else if (ackhavereset) begin
      havereset_d = 1'b0;
    end else begin
      havereset_d = havereset_q;
    end
  end

  always_ff @(posedge clk or negedge dm_rst_n_sync) begin
    if (!dm_rst_n_sync) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      sys_rst_n_q  <= 1'b0;
      hart_rst_n_q <= 1'b0;
      havereset_q  <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_rst_n_q  <= sys_rst_n_d;
      hart_rst_n_q <= hart_rst_n_d;
      havereset_q  <= havereset_d;
      busy_q       <= busy_d;
    end
  end

  assign dm_rst_n   = dm_rst_n_sync;
  assign sys_rst_n  = sys_rst_n_q;
  assign hart_rst_n = hart_rst_n_q;
  assign havereset  = havereset_q;
  assign busy       = busy_q;

endmodule
